// File: rtl/ntt_writeback_ctrl.sv
// NTT write-back controller: packs butterfly results into 60-bit words for the ping-pong RAM banks.
// Define NTT_WB_OUTREG_EN to add an output register stage (write latency 2 instead of 1).
module ntt_writeback_ctrl #(
  parameter int WORDS_PER_STAGE = 64,
  parameter int LAST_STAGE      = 11,
  parameter int LOG_CORE_COUNT  = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [29:0] r1,
  input  logic [29:0] r2,
  input  logic [29:0] r3,
  input  logic [29:0] r4,
  output logic [3:0]  log_m,
  output logic        upper_write_enable,
  output logic        lower_write_enable,
  output logic [8:0]  upper_write_address,
  output logic [8:0]  lower_write_address,
  output logic [59:0] upper_data_input,
  output logic [59:0] lower_data_input,
  output logic        write_select,
  output logic        busy,
  output logic        done,
  output logic        err
);

  if (WORDS_PER_STAGE < 2 || WORDS_PER_STAGE > 512 || LAST_STAGE < 0 || LAST_STAGE > 15 ||
      LOG_CORE_COUNT < 0) begin : g_param_check
    $error("ntt_writeback_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [8:0] BEAT_LAST  = 9'(WORDS_PER_STAGE - 1);
  localparam logic [3:0] STAGE_LAST = 4'(LAST_STAGE);

  // Even stages swap across the butterfly pair; odd stages write straight through.
  function automatic logic [119:0] pack_words(input logic odd, input logic [29:0] a1,
                                              input logic [29:0] a2, input logic [29:0] a3,
                                              input logic [29:0] a4);
    if (odd) begin
      return {a2, a1, a4, a3};
    end else begin
      return {a3, a1, a4, a2};
    end
  endfunction

  state_t      state_r, state_nxt_s;
  logic [8:0]  beat_r, beat_nxt_s;
  logic [3:0]  stage_r, stage_nxt_s;
  logic        err_r, err_nxt_s;
  logic        wr_s, stage_end_s, start_acc_s;
  logic        we1_r, tog1_r, ws_r, busy_r, done_r;
  logic [8:0]  addr1_r;
  logic [59:0] up1_r, lo1_r;
  logic        we_s, tog_set_s, done_set_s;
  logic [8:0]  addr_s;
  logic [59:0] up_s, lo_s;

  // Next-state, counter and error-flag logic.
  always_comb begin
    state_nxt_s = state_r;
    beat_nxt_s  = beat_r;
    stage_nxt_s = stage_r;
    err_nxt_s   = err_r;
    wr_s        = 1'b0;
    stage_end_s = 1'b0;
    start_acc_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          state_nxt_s = S_RUN;
          beat_nxt_s  = 9'd0;
          stage_nxt_s = 4'd0;
          err_nxt_s   = 1'b0;
        end else if (in_valid) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          wr_s = 1'b1;
          if (beat_r == BEAT_LAST) begin
            beat_nxt_s  = 9'd0;
            stage_end_s = 1'b1;
            if (stage_r == STAGE_LAST) begin
              state_nxt_s = S_DONE;
            end else begin
              stage_nxt_s = stage_r + 4'd1;
            end
          end else begin
            beat_nxt_s = beat_r + 9'd1;
          end
        end else begin
          beat_nxt_s = beat_r;
        end
      end
      S_DONE: begin
        state_nxt_s = S_IDLE;
        stage_nxt_s = 4'd0;
        if (in_valid) begin
          err_nxt_s = 1'b1;
        end else begin
          err_nxt_s = err_r;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

`ifdef NTT_WB_OUTREG_EN
  logic        we2_r, tog2_r, done1_r;
  logic [8:0]  addr2_r;
  logic [59:0] up2_r, lo2_r;

  // Extra output stage; the done and bank-toggle pulses ride along to stay aligned with writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we2_r   <= 1'b0;
      addr2_r <= 9'd0;
      up2_r   <= 60'd0;
      lo2_r   <= 60'd0;
      tog2_r  <= 1'b0;
      done1_r <= 1'b0;
    end else begin
      we2_r   <= we1_r;
      addr2_r <= addr1_r;
      up2_r   <= up1_r;
      lo2_r   <= lo1_r;
      tog2_r  <= tog1_r;
      done1_r <= (state_r == S_DONE);
    end
  end

  assign we_s       = we2_r;
  assign addr_s     = addr2_r;
  assign up_s       = up2_r;
  assign lo_s       = lo2_r;
  assign tog_set_s  = tog2_r;
  assign done_set_s = done1_r;
`else
  assign we_s       = we1_r;
  assign addr_s     = addr1_r;
  assign up_s       = up1_r;
  assign lo_s       = lo1_r;
  assign tog_set_s  = tog1_r;
  assign done_set_s = (state_r == S_DONE);
`endif

  // State, counters and the first registered write stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      beat_r  <= 9'd0;
      stage_r <= 4'd0;
      err_r   <= 1'b0;
      we1_r   <= 1'b0;
      addr1_r <= 9'd0;
      up1_r   <= 60'd0;
      lo1_r   <= 60'd0;
      tog1_r  <= 1'b0;
      ws_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      beat_r  <= beat_nxt_s;
      stage_r <= stage_nxt_s;
      err_r   <= err_nxt_s;
      we1_r   <= wr_s;
      if (wr_s) begin
        addr1_r        <= beat_r;
        {up1_r, lo1_r} <= pack_words(stage_r[0], r1, r2, r3, r4);
      end
      tog1_r <= stage_end_s;
      done_r <= done_set_s;
      if (tog_set_s) begin
        ws_r <= ~ws_r;
      end
      // busy falls in the same cycle the done pulse appears
      if (start_acc_s) begin
        busy_r <= 1'b1;
      end else if (done_set_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign log_m               = stage_r;
  assign upper_write_enable  = we_s;
  assign lower_write_enable  = we_s;
  assign upper_write_address = addr_s;
  assign lower_write_address = addr_s;
  assign upper_data_input    = up_s;
  assign lower_data_input    = lo_s;
  assign write_select        = ws_r;
  assign busy                = busy_r;
  assign done                = done_r;
  assign err                 = err_r;

endmodule

// File: tb/tb_ntt_writeback_ctrl.sv
// Scoreboard bench for ntt_writeback_ctrl with 4 words per stage and stages 0..2.
module tb_ntt_writeback_ctrl;
  localparam int WPS  = 4;
  localparam int LAST = 2;
`ifdef NTT_WB_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [29:0] r1 = 30'd0, r2 = 30'd0, r3 = 30'd0, r4 = 30'd0;
  logic [3:0]  log_m;
  logic        upper_write_enable, lower_write_enable;
  logic [8:0]  upper_write_address, lower_write_address;
  logic [59:0] upper_data_input, lower_data_input;
  logic        write_select, busy, done, err;

  ntt_writeback_ctrl #(.WORDS_PER_STAGE(WPS), .LAST_STAGE(LAST), .LOG_CORE_COUNT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .log_m(log_m),
    .upper_write_enable(upper_write_enable), .lower_write_enable(lower_write_enable),
    .upper_write_address(upper_write_address), .lower_write_address(lower_write_address),
    .upper_data_input(upper_data_input), .lower_data_input(lower_data_input),
    .write_select(write_select), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0]  addr;
    logic [59:0] up;
    logic [59:0] lo;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [29:0] a, input logic [29:0] b, input logic [29:0] c,
                            input logic [29:0] d, input logic [8:0] addr,
                            input logic [59:0] up, input logic [59:0] lo,
                            input int gap, input logic st);
    exp_t e;
    r1 = a; r2 = b; r3 = c; r4 = d;
    in_valid = 1'b1;
    start = st;
    e.addr = addr;
    e.up   = up;
    e.lo   = lo;
    e.cyc  = cyc + LAT;
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    start = 1'b0;
    repeat (gap) tick();
  endtask

  // Monitor: pops one expectation per write strobe and tracks done pulses.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (upper_write_enable || lower_write_enable) begin
        if (q.size() == 0) begin
          check("unexpected_write", {63'd0, upper_write_enable | lower_write_enable}, 64'd0);
        end else begin
          e = q.pop_front();
          check("upper_we", {63'd0, upper_write_enable}, 64'd1);
          check("lower_we", {63'd0, lower_write_enable}, 64'd1);
          check("upper_addr", {55'd0, upper_write_address}, {55'd0, e.addr});
          check("lower_addr", {55'd0, lower_write_address}, {55'd0, e.addr});
          check("upper_data", {4'd0, upper_data_input}, {4'd0, e.up});
          check("lower_data", {4'd0, lower_data_input}, {4'd0, e.lo});
          check("write_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_at_done", {63'd0, busy}, 64'd0);
      end
    end
  end

  initial begin
    int w;
    // Power-on reset state
    repeat (2) tick();
    check("rst_we", {63'd0, upper_write_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_ws", {63'd0, write_select}, 64'd0);
    check("rst_logm", {60'd0, log_m}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    rst = 1'b0;
    tick();

    // Abort with rst while the 5th beat's write is on the bus
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    for (int b = 0; b < WPS; b++)
      drive_beat(30'd1, 30'd2, 30'd3, 30'd4, 9'(b), {30'd3, 30'd1}, {30'd4, 30'd2}, 0, 1'b0);
    drive_beat(30'd5, 30'd6, 30'd7, 30'd8, 9'd0, {30'd6, 30'd5}, {30'd8, 30'd7}, 0, 1'b0);
    repeat (LAT - 1) tick();
    check("pre_rst_we", {63'd0, upper_write_enable}, 64'd1);
    check("pre_rst_ws", {63'd0, write_select}, 64'd1);
    check("pre_rst_logm", {60'd0, log_m}, 64'd1);
    #2 rst = 1'b1;
    #1;
    q.delete();
    check("abort_upper_we", {63'd0, upper_write_enable}, 64'd0);
    check("abort_lower_we", {63'd0, lower_write_enable}, 64'd0);
    check("abort_upper_data", {4'd0, upper_data_input}, 64'd0);
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_ws", {63'd0, write_select}, 64'd0);
    check("abort_logm", {60'd0, log_m}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // in_valid while idle must not write and must set err; start clears it
    r1 = 30'd9; r2 = 30'd9; r3 = 30'd9; r4 = 30'd9;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (LAT) tick();
    check("idle_we", {63'd0, upper_write_enable}, 64'd0);
    check("idle_err", {63'd0, err}, 64'd1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_err", {63'd0, err}, 64'd0);
    check("run_busy", {63'd0, busy}, 64'd1);
    check("stage0_logm", {60'd0, log_m}, 64'd0);

    // Full run, in_valid every other cycle; stray start at beat 2 must be ignored
    for (int b = 0; b < WPS; b++)
      drive_beat(30'd1, 30'd2, 30'd3, 30'd4, 9'(b), {30'd3, 30'd1}, {30'd4, 30'd2}, 1, b == 2);
    repeat (3) tick();
    check("stage0_ws", {63'd0, write_select}, 64'd1);
    check("stage1_logm", {60'd0, log_m}, 64'd1);
    for (int b = 0; b < WPS; b++)
      drive_beat(30'd5, 30'd6, 30'd7, 30'd8, 9'(b), {30'd6, 30'd5}, {30'd8, 30'd7}, 1, 1'b0);
    repeat (3) tick();
    check("stage1_ws", {63'd0, write_select}, 64'd0);
    check("stage2_logm", {60'd0, log_m}, 64'd2);
    check("stage2_busy", {63'd0, busy}, 64'd1);
    for (int b = 0; b < WPS; b++)
      drive_beat(30'd9, 30'd10, 30'd11, 30'd12, 9'(b), {30'd11, 30'd9}, {30'd12, 30'd10}, 1, 1'b0);
    w = 0;
    while (done_cnt == 0 && w < 50) begin
      tick();
      w++;
    end
    check("done_seen", 64'(done_cnt), 64'd1);
    repeat (3) tick();
    check("done_once", 64'(done_cnt), 64'd1);
    check("final_ws", {63'd0, write_select}, 64'd1);
    check("final_busy", {63'd0, busy}, 64'd0);
    check("final_logm", {60'd0, log_m}, 64'd0);
    check("final_err", {63'd0, err}, 64'd0);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
